video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the videogen (CLUT) subsystem.
- Derives horizontal/vertical counters, blanking, sync and line/frame strobes from the 6 MHz pixel clock.
- nBLANK_D drives the videogen nCLR input. Its palette index latch is then cleared (index 0) during blanking.
- nBLANK_D and SYNC_D are delayed by PIPE_DELAY clocks so they line up with the videogen RGB output, which lags the index input by 2 clocks.

Parameters:
H_TOTAL, 384, pixel clocks per line (HCOUNT wraps H_TOTAL-1 -> 0)
H_ACTIVE, 288, visible pixels per line (HCOUNT 0..H_ACTIVE-1)
HSYNC_START, 320, HCOUNT value at which HSYNC asserts
HSYNC_WIDTH, 32, HSYNC length in pixel clocks
V_TOTAL, 264, lines per frame
V_ACTIVE, 224, visible lines (VCOUNT 0..V_ACTIVE-1)
VSYNC_START, 240, VCOUNT line on which VSYNC asserts
VSYNC_WIDTH, 8, VSYNC length in lines
PIPE_DELAY, 2, clocks of delay on nBLANK_D/SYNC_D (legal range 0..8)

Ports:
CLK_6MD  in  1  pixel clock; all state on rising edge
nRESET  in  1  asynchronous active-low reset
ENABLE  in  1  1 = advance counters; 0 = freeze all state (delay line included)
HCOUNT  out  9  horizontal position
VCOUNT  out  9  vertical line
HBLANK  out  1  high when HCOUNT >= H_ACTIVE
VBLANK  out  1  high when VCOUNT >= V_ACTIVE
nHSYNC  out  1  active-low horizontal sync
nVSYNC  out  1  active-low vertical sync
LINE_START  out  1  one-clock pulse, high while HCOUNT==0
FRAME_START  out  1  one-clock pulse, high while HCOUNT==0 and VCOUNT==0
nBLANK_D  out  1  ~(HBLANK|VBLANK) delayed PIPE_DELAY clocks; feeds videogen nCLR
SYNC_D  out  1  composite sync (nHSYNC & nVSYNC) delayed PIPE_DELAY clocks, active-low

Behaviour:
- Reset (nRESET low, asynchronous):
  - HCOUNT=0, VCOUNT=0, HBLANK=0, VBLANK=0, nHSYNC=1, nVSYNC=1.
  - LINE_START=1 and FRAME_START=1; these follow the count decode.
  - Every delay-line stage is reset to nBLANK=0 (blanked) and SYNC=1, so nBLANK_D=0 and SYNC_D=1 until real values propagate.
- Counters, per clock with ENABLE=1:
  - HCOUNT increments; at H_TOTAL-1 it wraps to 0.
  - VCOUNT increments only on the HCOUNT wrap clock; at V_TOTAL-1 with HCOUNT wrapping, it wraps to 0.
- Counter widths: 9 bits, unsigned. Parameters must be >0 and <=511.
- Flag timing: all flags are registered and computed from the next-count value, so they are valid in the same cycle as the count they describe (zero skew to HCOUNT/VCOUNT).
- HSYNC: nHSYNC=0 for HCOUNT in [HSYNC_START, HSYNC_START+HSYNC_WIDTH-1]. If the window passes H_TOTAL-1 it does not wrap; it is truncated at H_TOTAL-1.
- VSYNC: nVSYNC=0 for every clock of lines VCOUNT in [VSYNC_START, VSYNC_START+VSYNC_WIDTH-1]. It changes only at the line boundary (HCOUNT==0). Truncated at V_TOTAL-1.
- Delay line:
  - PIPE_DELAY-deep shift register of {nBLANK, SYNC}.
  - Stage 0 samples the same-cycle flags.
  - PIPE_DELAY=0: nBLANK_D and SYNC_D are combinational copies of the current flags.
- ENABLE=0: every register, including the delay line, holds. Outputs are stable. Resuming continues from the exact held state, with no skipped or repeated count.
- Reset mid-frame: immediate asynchronous return to the reset state. The first rising edge after release with ENABLE=1 gives HCOUNT=1.
- Simultaneous wraps: on the clock where HCOUNT=H_TOTAL-1 and VCOUNT=V_TOTAL-1, both go to 0 together and FRAME_START asserts in that next cycle.
- Nominal defaults: 6.144 MHz / 384 = 16.0 kHz line rate; /264 = 60.6 Hz frame rate.

Test Plan:
- Reset then 384 clocks with ENABLE=1:
  - HCOUNT runs 1..383 then 0; VCOUNT becomes 1 at the wrap.
  - LINE_START is high only at HCOUNT=0.
  - HBLANK rises exactly when HCOUNT=288 and falls when HCOUNT=0.
- Horizontal sync: nHSYNC is low for exactly 32 clocks, HCOUNT 320..351, on every line. Bench checks the low count per line = 32.
- Full frame of 101376 clocks:
  - VBLANK is high for VCOUNT 224..263.
  - nVSYNC is low for lines 240..247 (8×384 = 3072 clocks).
  - FRAME_START fires once, at VCOUNT=0/HCOUNT=0.
  - VCOUNT wraps 263 -> 0 together with the HCOUNT wrap.
- Pipeline alignment, PIPE_DELAY=2: nBLANK_D falls exactly 2 clocks after HBLANK rises (HCOUNT=290) and rises 2 clocks after HCOUNT=0. SYNC_D mirrors nHSYNC&nVSYNC, delayed by 2.
- ENABLE low for 10 clocks at HCOUNT=100, VCOUNT=50: all outputs are frozen. After re-enable the next HCOUNT is 101 and no line length changes (still 384).
- nRESET pulsed low asynchronously (mid-clock) at HCOUNT=300, VCOUNT=245:
  - Outputs go immediately to 0/0, nHSYNC=nVSYNC=1, nBLANK_D=0.
  - After release, counting restarts from 0.
  - Repeat with PIPE_DELAY=0 and check that nBLANK_D equals ~(HBLANK|VBLANK) combinationally.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator for the 6 MHz pixel clock, upstream of the videogen (CLUT) block.
// Produces horizontal/vertical counters, blanking, sync and line/frame strobes. It also
// produces a delayed blank/sync pair that lines up with the videogen RGB output.
//
// Ports:
//   CLK_6MD      pixel clock, all state on rising edge
//   nRESET       asynchronous active-low reset
//   ENABLE       1 = advance, 0 = hold every register (delay line included)
//   HCOUNT       horizontal position, 0..H_TOTAL-1
//   VCOUNT       vertical line, 0..V_TOTAL-1
//   HBLANK       HCOUNT >= H_ACTIVE
//   VBLANK       VCOUNT >= V_ACTIVE
//   nHSYNC       active-low horizontal sync
//   nVSYNC       active-low vertical sync (whole lines)
//   LINE_START   high while HCOUNT == 0
//   FRAME_START  high while HCOUNT == 0 and VCOUNT == 0
//   nBLANK_D     ~(HBLANK|VBLANK) delayed PIPE_DELAY clocks, drives videogen nCLR
//   SYNC_D       nHSYNC & nVSYNC delayed PIPE_DELAY clocks, active-low
module video_timing_gen #(
  parameter int unsigned H_TOTAL     = 384,
  parameter int unsigned H_ACTIVE    = 288,
  parameter int unsigned HSYNC_START = 320,
  parameter int unsigned HSYNC_WIDTH = 32,
  parameter int unsigned V_TOTAL     = 264,
  parameter int unsigned V_ACTIVE    = 224,
  parameter int unsigned VSYNC_START = 240,
  parameter int unsigned VSYNC_WIDTH = 8,
  parameter int unsigned PIPE_DELAY  = 2
) (
  input  logic       CLK_6MD,
  input  logic       nRESET,
  input  logic       ENABLE,
  output logic [8:0] HCOUNT,
  output logic [8:0] VCOUNT,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       nHSYNC,
  output logic       nVSYNC,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic       nBLANK_D,
  output logic       SYNC_D
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
  // Sync windows are held one bit wider so START+WIDTH cannot overflow; the
  // count never exceeds *_TOTAL-1, so windows past the end truncate naturally.
  localparam logic [9:0] HS_BEG = 10'(HSYNC_START);
  localparam logic [9:0] HS_END = 10'(HSYNC_START + HSYNC_WIDTH);
  localparam logic [9:0] VS_BEG = 10'(VSYNC_START);
  localparam logic [9:0] VS_END = 10'(VSYNC_START + VSYNC_WIDTH);

  logic [8:0] h_next;
  logic [8:0] v_next;
  logic       nblank_cur;
  logic       sync_cur;

  always_comb begin
    h_next = HCOUNT + 9'd1;
    v_next = VCOUNT;
    if (HCOUNT == H_LAST) begin
      h_next = '0;
      v_next = (VCOUNT == V_LAST) ? '0 : VCOUNT + 9'd1;
    end
  end

  // Flags are decoded from the next count so they land in the same cycle as
  // the count they describe.
  always_ff @(posedge CLK_6MD or negedge nRESET) begin
    if (!nRESET) begin
      HCOUNT      <= '0;
      VCOUNT      <= '0;
      HBLANK      <= 1'b0;
      VBLANK      <= 1'b0;
      nHSYNC      <= 1'b1;
      nVSYNC      <= 1'b1;
      LINE_START  <= 1'b1;
      FRAME_START <= 1'b1;
    end else if (ENABLE) begin
      HCOUNT      <= h_next;
      VCOUNT      <= v_next;
      HBLANK      <= (h_next >= H_ACT);
      VBLANK      <= (v_next >= V_ACT);
      nHSYNC      <= !(({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END));
      nVSYNC      <= !(({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END));
      LINE_START  <= (h_next == '0);
      FRAME_START <= (h_next == '0) && (v_next == '0);
    end
  end

  assign nblank_cur = ~(HBLANK | VBLANK);
  assign sync_cur   = nHSYNC & nVSYNC;

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign nBLANK_D = nblank_cur;
      assign SYNC_D   = sync_cur;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] nblank_sr;
      logic [PIPE_DELAY-1:0] sync_sr;

      // Bit 0 takes the current flags; the truncating cast drops the oldest bit.
      always_ff @(posedge CLK_6MD or negedge nRESET) begin
        if (!nRESET) begin
          nblank_sr <= '0;
          sync_sr   <= '1;
        end else if (ENABLE) begin
          nblank_sr <= PIPE_DELAY'({nblank_sr, nblank_cur});
          sync_sr   <= PIPE_DELAY'({sync_sr, sync_cur});
        end
      end

      assign nBLANK_D = nblank_sr[PIPE_DELAY-1];
      assign SYNC_D   = sync_sr[PIPE_DELAY-1];
    end
  endgenerate

endmodule
